// File: rtl/lab1_idiv_int_div_base_if.sv
// Request/response stream bundle for the lab1 iterative divider:
// {dividend, divisor} in, {remainder, quotient} out, both val/rdy handshaked.
interface lab1_idiv_int_div_base_if;
    logic        istream_val;
    logic        istream_rdy;
    logic [63:0] istream_msg;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [63:0] ostream_msg;

    modport master (
        output istream_val,
        input  istream_rdy,
        output istream_msg,
        input  ostream_val,
        output ostream_rdy,
        input  ostream_msg
    );

    modport slave (
        input  istream_val,
        output istream_rdy,
        input  istream_msg,
        output ostream_val,
        input  ostream_rdy,
        output ostream_msg
    );
endinterface

// File: rtl/lab1_idiv_int_div_base.sv
// Fixed-latency unsigned 32-bit restoring divider: one quotient bit per cycle,
// 32 iterations from accept to result-valid, one request in flight at a time.
module lab1_idiv_int_div_base (
    input  logic                          clk,
    input  logic                          reset,
    lab1_idiv_int_div_base_if.slave       io
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic [4:0]  cnt;
    logic        accept;
    logic [64:0] step;
    logic        unused_rem_msb;

    // One restoring iteration: shift the next dividend bit into the partial
    // remainder and keep the trial subtraction only if it did not borrow.
    function automatic logic [64:0] div_step(
        input logic [31:0] r,
        input logic [31:0] q,
        input logic [31:0] d
    );
        logic [32:0] s;
        logic [32:0] t;
        s = {r, q[31]};
        t = s - {1'b0, d};
        if (!t[32])
            div_step = {t, q[30:0], 1'b1};
        else
            div_step = {s, q[30:0], 1'b0};
    endfunction

    assign accept = io.istream_val && (state == IDLE);
    assign step   = div_step(rem[31:0], quo, dvs);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (io.istream_val) state_next = CALC;
            CALC:    if (cnt == 5'd31)   state_next = DONE;
            DONE:    if (io.ostream_rdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                rem <= '0;
                quo <= io.istream_msg[63:32];
                dvs <= io.istream_msg[31:0];
                cnt <= '0;
            end else if (state == CALC) begin
                rem <= step[64:32];
                quo <= step[31:0];
                cnt <= cnt + 5'd1;
            end
        end
    end

    // Handshake outputs come only from the state register, never from inputs.
    assign io.istream_rdy = (state == IDLE);
    assign io.ostream_val = (state == DONE);
    assign io.ostream_msg = {rem[31:0], quo};

    // The partial remainder is always below the divisor, so its MSB stays 0.
    assign unused_rem_msb = rem[32];
endmodule

// File: tb/tb_lab1_idiv_int_div_base.sv
// Directed bench for the iterative divider: a timing/arithmetic reference model
// checked every cycle, plus literal expectations for the listed corner cases.
module tb_lab1_idiv_int_div_base;
    logic clk;
    logic reset;

    lab1_idiv_int_div_base_if io ();

    lab1_idiv_int_div_base dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Golden arithmetic; a zero divisor yields all-ones quotient and the dividend back.
    function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0)
            return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    // Reference model: a request is accepted when idle, its result becomes
    // visible 32 cycles later and leaves on the first ready cycle after that.
    int          cyc = 0;
    int          acc_cyc = 0;
    logic        busy = 1'b0;
    logic        armed = 1'b0;
    logic [63:0] exp_msg = '0;
    int          n_acc = 0;
    int          n_out = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            armed <= 1'b1;
            busy  <= 1'b0;
        end else if (!busy && io.istream_val) begin
            busy    <= 1'b1;
            acc_cyc <= cyc;
            exp_msg <= golden(io.istream_msg[63:32], io.istream_msg[31:0]);
            n_acc   <= n_acc + 1;
        end else if (busy && (cyc - acc_cyc >= 33) && io.ostream_rdy) begin
            busy  <= 1'b0;
            n_out <= n_out + 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model istream_rdy", {63'd0, io.istream_rdy}, {63'd0, !busy});
            chk("model ostream_val", {63'd0, io.ostream_val},
                {63'd0, busy && (cyc - acc_cyc >= 33)});
            if (busy && (cyc - acc_cyc >= 33))
                chk("model ostream_msg", io.ostream_msg, exp_msg);
        end
    end

    logic trace_on = 1'b0;
    always @(negedge clk) begin
        if (trace_on)
            $display("%b/%b:%h | %s%0d | %b/%b:%h",
                     io.istream_val, io.istream_rdy, io.istream_msg,
                     dut.state.name(), dut.cnt,
                     io.ostream_val, io.ostream_rdy, io.ostream_msg);
    end

    // Issue one request from a negedge, check 32-cycle latency and the literal
    // result; if the sink is ready the transfer completes before returning.
    task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic [31:0] eq);
        int n;
        chk({name, " model"}, golden(a, b), {er, eq});
        n = 0;
        while (!io.istream_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, " rdy wait"}, {63'd0, io.istream_rdy}, 64'd1);
        io.istream_val = 1'b1;
        io.istream_msg = {a, b};
        @(posedge clk);
        @(negedge clk);
        io.istream_val = 1'b0;
        n = 0;
        while (!io.ostream_val && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({name, " latency"}, 64'(n), 64'd32);
        chk({name, " result"}, io.ostream_msg, {er, eq});
        if (io.ostream_rdy) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, " drained"}, {63'd0, io.ostream_val}, 64'd0);
        end
    endtask

    logic [31:0] sa [50];
    logic [31:0] sb [50];

    initial begin
        int idx;
        int t;
        int last;
        int base_acc;
        int base_out;
        logic acc;
        logic [63:0] held;

        reset          = 1'b1;
        io.istream_val = 1'b0;
        io.istream_msg = '0;
        io.ostream_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset istream_rdy", {63'd0, io.istream_rdy}, 64'd1);
        chk("reset ostream_val", {63'd0, io.ostream_val}, 64'd0);
        chk("reset ostream_msg", io.ostream_msg, 64'd0);

        trace_on = 1'b1;
        run_one("100/7", 32'd100, 32'd7, 32'd2, 32'd14);
        trace_on = 1'b0;
        run_one("max/1", 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF);
        run_one("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);
        run_one("3/msb", 32'd3, 32'h8000_0000, 32'd3, 32'd0);
        run_one("0/9", 32'd0, 32'd9, 32'd0, 32'd0);
        run_one("5/0", 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_one("deadbeef/0", 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 32'hFFFF_FFFF);

        // Backpressure: the result must hold still while the sink stalls.
        base_out = n_out;
        io.ostream_rdy = 1'b0;
        run_one("bp 1000/7", 32'd1000, 32'd7, 32'd6, 32'd142);
        held = io.ostream_msg;
        repeat (10) begin
            @(negedge clk);
            chk("bp val held", {63'd0, io.ostream_val}, 64'd1);
            chk("bp msg held", io.ostream_msg, held);
            chk("bp istream_rdy low", {63'd0, io.istream_rdy}, 64'd0);
        end
        io.ostream_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp released val", {63'd0, io.ostream_val}, 64'd0);
        chk("bp released rdy", {63'd0, io.istream_rdy}, 64'd1);
        chk("bp single transfer", 64'(n_out - base_out), 64'd1);

        // Back-to-back stream; off-acceptance cycles carry junk that must be ignored.
        for (int i = 0; i < 50; i++) begin
            sa[i] = $urandom;
            sb[i] = (i % 7 == 3) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom);
        end
        base_acc = n_acc;
        base_out = n_out;
        idx  = 0;
        t    = 0;
        last = -1;
        while (idx < 50 && t < 3000) begin
            io.istream_val = 1'b1;
            acc = io.istream_rdy;
            io.istream_msg = acc ? {sa[idx], sb[idx]} : {$urandom, $urandom};
            @(posedge clk);
            t++;
            if (acc) begin
                if (last >= 0)
                    chk("stream spacing", 64'(t - last), 64'd34);
                last = t;
                idx++;
            end
            @(negedge clk);
        end
        io.istream_val = 1'b0;
        chk("stream all issued", 64'(idx), 64'd50);
        t = 0;
        while (n_out - base_out < 50 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("stream accepts", 64'(n_acc - base_acc), 64'd50);
        chk("stream results", 64'(n_out - base_out), 64'd50);

        // Reset in the middle of CALC discards the request.
        @(negedge clk);
        io.istream_val = 1'b1;
        io.istream_msg = {32'd1000, 32'd3};
        @(posedge clk);
        @(negedge clk);
        io.istream_val = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midreset istream_rdy", {63'd0, io.istream_rdy}, 64'd1);
        chk("midreset ostream_val", {63'd0, io.ostream_val}, 64'd0);
        chk("midreset ostream_msg", io.ostream_msg, 64'd0);
        repeat (40) @(negedge clk);
        run_one("20/6", 32'd20, 32'd6, 32'd2, 32'd3);

        // Reset beats a simultaneous request in IDLE.
        base_acc = n_acc;
        reset          = 1'b1;
        io.istream_val = 1'b1;
        io.istream_msg = {32'd77, 32'd5};
        @(posedge clk);
        @(negedge clk);
        reset          = 1'b0;
        io.istream_val = 1'b0;
        chk("reset vs val rdy", {63'd0, io.istream_rdy}, 64'd1);
        chk("reset vs val no accept", 64'(n_acc - base_acc), 64'd0);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lab1_idiv_int_div_base.md
# lab1_idiv_int_div_base

Fixed-latency iterative unsigned 32-bit integer divider: the inverse companion to the lab1 iterative multiplier. It shares the multiplier's val/rdy stream interface and its one-bit-per-cycle shift/subtract style. It accepts a {dividend, divisor} message, runs 32 restoring-division iterations, and returns {remainder, quotient}. It sits in the lab1 arithmetic unit beside the multiplier, and test sources and sinks drive and drain it.

## Interface
- No parameters; all datapath widths are fixed at 32 bits.
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, synchronous, active-high
- istream_val  in  1  request valid
- istream_rdy  out  1  divider can accept a request
- istream_msg  in  64  [63:32] dividend, [31:0] divisor, both unsigned
- ostream_val  out  1  result valid
- ostream_rdy  in  1  consumer accepts result
- ostream_msg  out  64  [63:32] remainder, [31:0] quotient

## Operation
- **Handshakes.** A transfer occurs on a rising edge where val && rdy are both high. One request is in flight at a time.
- **FSM states.** IDLE, CALC, DONE (2-bit encoding). Reset forces IDLE.
  - IDLE -> CALC on an istream handshake. Otherwise IDLE holds.
  - CALC -> DONE when the iteration counter reaches 31 and that iteration completes. Otherwise CALC holds, and the counter increments.
  - DONE -> IDLE on an ostream handshake. Otherwise DONE holds, and the result stays stable.
- **Output decoding.** istream_rdy = (state == IDLE). ostream_val = (state == DONE). Both are decoded only from the state register, with no combinational path from istream_val or ostream_rdy.
- **Datapath registers.**
  - R: 33-bit partial remainder.
  - Q: 32-bit dividend/quotient shift register.
  - D: 32-bit divisor.
  - cnt: 5-bit iteration counter.
- **On accept.** R = 0, Q = dividend, D = divisor, cnt = 0.
- **Each CALC cycle (one iteration).**
  - Form S = {R[31:0], Q[31]} (33 bits).
  - Compute T = S − {1'b0, D} at 33 bits.
  - If T[32] == 0: R = T and Q = {Q[30:0], 1}.
  - Else: R = S and Q = {Q[30:0], 0}.
- **Result.** ostream_msg = {R[31:0], Q}. It is valid and stable throughout DONE.
- **Divide by zero.** No special case is needed: the algorithm naturally yields quotient = 0xFFFFFFFF and remainder = dividend. This is the required result.
- **Unused inputs.** istream_msg is ignored outside an IDLE handshake. ostream_rdy is ignored outside DONE.
- **Line trace.** Shows the istream val/rdy/msg, the state name (IDLE/CALC/DONE plus cnt), and the ostream val/rdy/msg.

## Timing
- **Reset values.** The state is IDLE, so istream_rdy = 1 and ostream_val = 0. ostream_msg = 0, because R, Q, D and cnt all reset to 0.
- **Latency.** With the request accepted at edge k, iterations occur at edges k+1..k+32. ostream_val is high in the cycle following edge k+32. That is 32 cycles from accept to result-valid, independent of operand values.
- **Output handshake and return to IDLE.**
  - If ostream_rdy is high in the first DONE cycle, the result transfers at edge k+33.
  - istream_rdy rises in the cycle after the ostream handshake. There is no same-cycle bypass, so the minimum initiation interval is 34 cycles.
- **Backpressure.** DONE holds indefinitely while ostream_rdy = 0. ostream_msg must not change during this time, and istream_rdy stays 0.
- **Stray requests.** istream_val asserted during CALC or DONE is not accepted and must not disturb the computation.
- **Reset mid-operation.** A reset asserted in any state at any cycle wins over all other events. The in-flight request is discarded, and at the next edge the block enters IDLE with the reset values above. No stale ostream_val may appear afterwards.
- **Simultaneous events.** In IDLE with istream_val = 1 and reset = 1, reset wins and nothing is accepted.

## Test plan
- **Basic operation.** 100 / 7 with the sink always ready -> ostream_msg = {0x00000002, 0x0000000E}; ostream_val first high exactly 32 cycles after the accept edge.
- **Operand corners.**
  - 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
  - 0xFFFFFFFF / 0xFFFFFFFF -> {0, 1}.
  - 3 / 0x80000000 -> {3, 0}.
  - 0 / 9 -> {0, 0}.
- **Divide by zero.** 5 / 0 -> {0x00000005, 0xFFFFFFFF}. 0xDEADBEEF / 0 -> {0xDEADBEEF, 0xFFFFFFFF}.
- **Backpressure.** Hold ostream_rdy = 0 for 10 cycles in DONE -> ostream_val stays 1, the message is unchanged, and istream_rdy stays 0. On release, a single transfer occurs, then IDLE.
- **Back-to-back stream.** Source val always high with 50 random operand pairs (including divisor 0) -> every result matches the golden {a % b, a / b}, with the div-by-zero convention applied. Each request is accepted exactly once, with a 34-cycle spacing.
- **Reset mid-operation.** Assert reset at CALC cycle 15 -> the next cycle has istream_rdy = 1 and ostream_val = 0. A following request 20 / 6 returns {2, 3} with normal latency.
